instr_fetch_unit: RTL and testbench

//  Fetch stage between the 64-bit program counter and decode. Takes the

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_queue.sv | 102 ++++++++++
 rtl/instr_fetch_unit.sv | 76 +++++++
 tb/tb_instr_fetch_unit.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared widths and the queue entry type for the fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pkg;

   localparam int FETCH_ADDR_W  = 64;
   localparam int FETCH_INSTR_W = 32;
   localparam int INSTR_BYTES   = 4;

   typedef struct packed {
      logic [FETCH_ADDR_W-1:0]  pc;
      logic [FETCH_INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : Three-pointer (alloc/fill/read) entry array plus a drop counter
//            for responses that belong to requests killed by a redirect.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     alloc_en,
   input  logic [FETCH_ADDR_W-1:0]  alloc_pc,
   input  logic                     rsp_valid,
   input  logic [FETCH_INSTR_W-1:0] rsp_data,
   input  logic                     rd_en,
   input  logic                     flush,
   output logic                     has_room,
   output logic                     head_valid,
   output fetch_entry_t             head
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   logic [PTR_W-1:0] alloc_ptr_q, alloc_ptr_d;
   logic [PTR_W-1:0] fill_ptr_q,  fill_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q,    rd_ptr_d;
   logic [PTR_W-1:0] drop_cnt_q,  drop_cnt_d;
   fetch_entry_t     entries_q [DEPTH];
   fetch_entry_t     entries_d [DEPTH];

   logic [PTR_W-1:0] w_in_use;
   logic [PTR_W-1:0] w_in_flight;
   logic [PTR_W:0]   w_total;
   logic             w_drop_now;

   assign w_in_use    = alloc_ptr_q - rd_ptr_q;
   assign w_in_flight = alloc_ptr_q - fill_ptr_q;
   assign w_total     = {1'b0, w_in_use} + {1'b0, drop_cnt_q};
   // Killed-but-unanswered requests still occupy memory slots, so they count.
   assign has_room    = (w_total < (PTR_W+1)'(DEPTH));
   assign w_drop_now  = (drop_cnt_q != '0);

   assign head_valid  = (rd_ptr_q != fill_ptr_q);
   assign head        = entries_q[rd_ptr_q[IDX_W-1:0]];

   always_comb begin
      alloc_ptr_d = alloc_ptr_q;
      fill_ptr_d  = fill_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      drop_cnt_d  = drop_cnt_q;
      entries_d   = entries_q;
      if (flush) begin
         // Every response still owed is now stale; one arriving right now is consumed here.
         rd_ptr_d   = alloc_ptr_q;
         fill_ptr_d = alloc_ptr_q;
         drop_cnt_d = drop_cnt_q + w_in_flight - {{(PTR_W-1){1'b0}}, rsp_valid};
      end else begin
         if (alloc_en) begin
            entries_d[alloc_ptr_q[IDX_W-1:0]].pc = alloc_pc;
            alloc_ptr_d = alloc_ptr_q + 1'b1;
         end
         if (rsp_valid) begin
            if (w_drop_now) begin
               drop_cnt_d = drop_cnt_q - 1'b1;
            end else begin
               entries_d[fill_ptr_q[IDX_W-1:0]].instr = rsp_data;
               fill_ptr_d = fill_ptr_q + 1'b1;
            end
         end
         if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         alloc_ptr_q <= '0;
         fill_ptr_q  <= '0;
         rd_ptr_q    <= '0;
         drop_cnt_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i] <= '0;
         end
      end else begin
         alloc_ptr_q <= alloc_ptr_d;
         fill_ptr_q  <= fill_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         drop_cnt_q  <= drop_cnt_d;
         for (int i = 0; i < DEPTH; i++) begin
            entries_q[i] <= entries_d[i];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : Fetch stage: issues in-order instruction-memory requests, queues
//            returned instructions with their PCs and computes the next PC.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter int ADDR_W  = FETCH_ADDR_W,
   parameter int INSTR_W = FETCH_INSTR_W,
   parameter int DEPTH   = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [ADDR_W-1:0]  pc_in,
   output logic [ADDR_W-1:0]  pc_next,
   output logic               imem_req_valid,
   output logic [ADDR_W-1:0]  imem_req_addr,
   input  logic               imem_req_ready,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               dec_valid,
   output logic [INSTR_W-1:0] dec_instr,
   output logic [ADDR_W-1:0]  dec_pc,
   input  logic               dec_ready
);

   logic         w_has_room;
   logic         w_head_valid;
   logic         w_accept;
   logic         w_fire;
   fetch_entry_t w_head;

   // Request valid deliberately ignores imem_req_ready to keep the handshake stable.
   assign imem_req_valid = !reset && !redirect_valid && w_has_room;
   assign imem_req_addr  = pc_in;
   assign w_accept       = imem_req_valid && imem_req_ready;

   assign dec_valid      = !reset && w_head_valid;
   assign dec_instr      = w_head.instr;
   assign dec_pc         = w_head.pc;
   assign w_fire         = dec_valid && dec_ready && !redirect_valid;

   always_comb begin
      pc_next = pc_in;
      if (reset) begin
         pc_next = pc_in;
      end else if (redirect_valid) begin
         pc_next = {redirect_pc[ADDR_W-1:2], 2'b00};
      end else if (w_accept) begin
         pc_next = pc_in + ADDR_W'(INSTR_BYTES);
      end
   end

   fetch_queue #(
      .DEPTH      (DEPTH)
   ) u_queue (
      .clk        (clk),
      .reset      (reset),
      .alloc_en   (w_accept),
      .alloc_pc   (pc_in),
      .rsp_valid  (imem_rsp_valid),
      .rsp_data   (imem_rsp_data),
      .rd_en      (w_fire),
      .flush      (redirect_valid),
      .has_room   (w_has_room),
      .head_valid (w_head_valid),
      .head       (w_head)
   );

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Self-checking bench: combinational vector table, directed
//            multi-cycle sequences and random traffic against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] pc_in;
   logic [63:0] pc_next;
   logic        imem_req_valid;
   logic [63:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        dec_valid;
   logic [31:0] dec_instr;
   logic [63:0] dec_pc;
   logic        dec_ready;

   always #5 clk = ~clk;

   instr_fetch_unit #(.ADDR_W(64), .INSTR_W(32), .DEPTH(DEPTH)) u_dut (
      .clk            (clk),
      .reset          (reset),
      .pc_in          (pc_in),
      .pc_next        (pc_next),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .dec_valid      (dec_valid),
      .dec_instr      (dec_instr),
      .dec_pc         (dec_pc),
      .dec_ready      (dec_ready)
   );

   typedef struct { logic [63:0] pc; bit live; } flight_t;
   typedef struct { logic [63:0] pc; logic [31:0] instr; } ready_t;
   typedef struct { logic [63:0] addr; int due; } mem_t;
   typedef struct {
      bit rst; logic [63:0] pc; bit rdy; bit redir; logic [63:0] rpc;
      bit e_rv; logic [63:0] e_pn; bit e_dv;
   } vec_t;

   flight_t     inflight[$];
   ready_t      readyq[$];
   mem_t        memq[$];
   logic [63:0] acc_addrs[$];
   logic [63:0] fired_pcs[$];
   logic [63:0] pc_model;
   int          cyc = 0;
   int          last_due = 0;
   int          lat_fix = 1;
   int          n_chk = 0;
   int          n_err = 0;

   function automatic logic [31:0] instr_of(input logic [63:0] a);
      return a[33:2] ^ a[63:32] ^ 32'hC0DE_1234;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_first(input string name, input logic [63:0] exp);
      if (fired_pcs.size() == 0) chk({name, "_none"}, 64'd0, 64'd1);
      else                       chk(name, fired_pcs[0], exp);
   endtask

   // One clock of stimulus: drive, predict, compare, advance the model.
   task automatic cycle(input bit rdy, input bit drdy, input bit redir,
                        input logic [63:0] rpc, input bit rst);
      bit          e_rv, e_dv, acc, fire, rsp;
      logic [63:0] e_pn;
      int          lat;
      flight_t     f;
      rsp = !rst && memq.size() > 0 && memq[0].due <= cyc;
      reset          = rst;
      pc_in          = pc_model;
      imem_req_ready = rdy;
      imem_rsp_valid = rsp;
      imem_rsp_data  = rsp ? instr_of(memq[0].addr) : $urandom;
      redirect_valid = redir;
      redirect_pc    = rpc;
      dec_ready      = drdy;
      e_rv = !rst && !redir && (inflight.size() + readyq.size() < DEPTH);
      acc  = e_rv && rdy;
      e_dv = !rst && readyq.size() > 0;
      fire = e_dv && drdy && !redir;
      e_pn = rst ? pc_model : redir ? {rpc[63:2], 2'b00} : acc ? pc_model + 64'd4 : pc_model;
      #1;
      chk("req_valid", {63'd0, imem_req_valid}, {63'd0, e_rv});
      if (e_rv) chk("req_addr", imem_req_addr, pc_model);
      chk("pc_next", pc_next, e_pn);
      chk("dec_valid", {63'd0, dec_valid}, {63'd0, e_dv});
      if (e_dv) begin
         chk("dec_pc", dec_pc, readyq[0].pc);
         chk("dec_instr", {32'd0, dec_instr}, {32'd0, readyq[0].instr});
      end
      if (fire) fired_pcs.push_back(readyq[0].pc);
      if (acc)  acc_addrs.push_back(pc_model);
      @(posedge clk);
      if (rst) begin
         inflight.delete(); readyq.delete(); memq.delete();
      end else begin
         if (rsp) void'(memq.pop_front());
         if (redir) begin
            if (rsp) void'(inflight.pop_front());
            foreach (inflight[i]) inflight[i].live = 1'b0;
            readyq.delete();
         end else begin
            if (fire) void'(readyq.pop_front());
            if (rsp) begin
               f = inflight.pop_front();
               if (f.live) readyq.push_back('{f.pc, instr_of(f.pc)});
            end
            if (acc) begin
               inflight.push_back('{pc_model, 1'b1});
               lat = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 3));
               if (cyc + lat <= last_due) last_due = last_due + 1;
               else                       last_due = cyc + lat;
               memq.push_back('{pc_model, last_due});
            end
         end
      end
      pc_model = e_pn;
      cyc++;
      #1;
   endtask

   task automatic do_reset();
      cycle(0, 0, 0, 64'd0, 1);
      cycle(0, 0, 0, 64'd0, 1);
      acc_addrs.delete();
      fired_pcs.delete();
   endtask

   vec_t vecs[7];

   initial begin
      vecs[0] = '{0, 64'h0,                   1, 0, 64'h0,    1, 64'h4,                   0};
      vecs[1] = '{0, 64'h100,                 0, 0, 64'h0,    1, 64'h100,                 0};
      vecs[2] = '{0, 64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 64'h0,    1, 64'h0,                   0};
      vecs[3] = '{0, 64'h40,                  1, 1, 64'h1002, 0, 64'h1000,                0};
      vecs[4] = '{0, 64'h40,                  0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0};
      vecs[5] = '{1, 64'h88,                  1, 0, 64'h0,    0, 64'h88,                  0};
      vecs[6] = '{0, 64'h7FFF_FFFF_FFFF_FFF8, 1, 0, 64'h0,    1, 64'h7FFF_FFFF_FFFF_FFFC, 0};

      pc_model = 64'd0;
      do_reset();

      // Combinational vectors from the empty post-reset state, all inside one clock period.
      imem_rsp_valid = 0;
      dec_ready      = 0;
      for (int i = 0; i < 7; i++) begin
         reset          = vecs[i].rst;
         pc_in          = vecs[i].pc;
         imem_req_ready = vecs[i].rdy;
         redirect_valid = vecs[i].redir;
         redirect_pc    = vecs[i].rpc;
         #1;
         chk($sformatf("vec%0d_req_valid", i), {63'd0, imem_req_valid}, {63'd0, vecs[i].e_rv});
         chk($sformatf("vec%0d_pc_next", i), pc_next, vecs[i].e_pn);
         chk($sformatf("vec%0d_dec_valid", i), {63'd0, dec_valid}, {63'd0, vecs[i].e_dv});
      end
      do_reset();

      // Straight-line fetch with one-cycle memory.
      lat_fix = 1; pc_model = 64'd0;
      for (int i = 0; i < 8; i++) cycle(1, 1, 0, 64'd0, 0);
      if (acc_addrs.size() >= 3) begin
         chk("t1_addr0", acc_addrs[0], 64'h0);
         chk("t1_addr1", acc_addrs[1], 64'h4);
         chk("t1_addr2", acc_addrs[2], 64'h8);
      end else chk("t1_n_addrs", 64'(acc_addrs.size()), 64'd3);
      chk_first("t1_first_dec", 64'h0);
      if (fired_pcs.size() >= 2) chk("t1_second_dec", fired_pcs[1], 64'h4);

      // Decode stalled: queue fills to DEPTH and then holds.
      do_reset();
      pc_model = 64'd0;
      for (int i = 0; i < 8; i++) cycle(1, 0, 0, 64'd0, 0);
      chk("t2_accepts", 64'(acc_addrs.size()), 64'd4);
      chk("t2_dec_pc", dec_pc, 64'h0);

      // Memory not ready for three cycles.
      do_reset();
      pc_model = 64'h2000;
      for (int i = 0; i < 3; i++) cycle(0, 1, 0, 64'd0, 0);
      chk("t3_no_accept", 64'(acc_addrs.size()), 64'd0);
      cycle(1, 1, 0, 64'd0, 0);
      chk("t3_accept", 64'(acc_addrs.size()), 64'd1);

      // Redirect with two requests in flight.
      do_reset();
      lat_fix = 3; pc_model = 64'd0;
      cycle(1, 1, 0, 64'd0, 0);
      cycle(1, 1, 0, 64'd0, 0);
      cycle(1, 1, 1, 64'h1002, 0);
      fired_pcs.delete();
      lat_fix = 1;
      for (int i = 0; i < 10; i++) cycle(1, 1, 0, 64'd0, 0);
      chk_first("t4_first_dec", 64'h1000);

      // Redirect coinciding with a response and a decode fire.
      do_reset();
      pc_model = 64'h3000;
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, 64'd0, 0);
      cycle(1, 1, 1, 64'h5000, 0);
      fired_pcs.delete();
      for (int i = 0; i < 8; i++) cycle(1, 1, 0, 64'd0, 0);
      chk_first("t5_first_dec", 64'h5000);

      // PC wrap, then reset in the middle of traffic.
      do_reset();
      pc_model = 64'hFFFF_FFFF_FFFF_FFFC;
      for (int i = 0; i < 5; i++) cycle(1, 0, 0, 64'd0, 0);
      if (acc_addrs.size() >= 2) chk("t6_wrap_addr", acc_addrs[1], 64'h0);
      else chk("t6_n_addrs", 64'(acc_addrs.size()), 64'd2);
      cycle(1, 1, 0, 64'd0, 1);
      cycle(1, 1, 0, 64'd0, 0);

      // Random traffic.
      lat_fix = 0;
      for (int i = 0; i < 1500; i++) begin
         logic [63:0] rpc;
         rpc = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) rpc[63:8] = '1;
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) > 1,
               $urandom_range(0, 24) == 0, rpc, $urandom_range(0, 99) == 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
